// File: rtl/approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// approx_mul_pipe
//
// Three-stage pipelined signed/unsigned multiplier with an optional truncated
// (approximate) mode and a multiply-accumulate path.
//
//   S1 : operand sign detection and magnitude extraction
//   S2 : 3-bit digit partial products (low-weight digits dropped when approx)
//   S3 : partial-product sum, sign application, accumulate, output register
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   A, B       in   W-bit operands
//   signA/B    in   1 = operand is two's complement, 0 = unsigned
//   approx     in   1 = drop digit products with i+j < TRUNC
//   acc_en     in   1 = add product to accumulator, output the sum
//   acc_clr    in   1 = zero accumulator before this item's add
//   in_valid   in   input handshake valid
//   in_ready   out  input handshake ready (= pipeline advance)
//   out_valid  out  output handshake valid
//   out_ready  in   output handshake ready
//   result_out out  ACC_W-bit signed result
// -----------------------------------------------------------------------------
module approx_mul_pipe #(
  parameter  int W     = 9,
  parameter  int TRUNC = 1,
  parameter  int GUARD = 8,
  localparam int ACC_W = 2 * W + GUARD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             signA,
  input  logic             signB,
  input  logic             approx,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result_out
);

  localparam int D   = W / 3;   // digits per operand
  localparam int NP  = D * D;   // number of digit products
  localparam int P_W = 2 * W;   // exact product magnitude width

  // Whole pipeline moves together; it only stalls when the output register
  // holds an item the consumer has not taken.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: sign / magnitude
  // ---------------------------------------------------------------------------
  logic         v1_q;
  logic [W-1:0] mag_a_q, mag_b_q;
  logic         neg1_q, ap1_q, en1_q, clr1_q;

  logic         a_neg, b_neg;
  logic [W-1:0] mag_a_d, mag_b_d;

  // Two's-complement negation in W bits maps -2^(W-1) onto 2^(W-1), which is
  // exactly the unsigned magnitude wanted, so no extra bit is needed.
  assign a_neg   = signA & A[W-1];
  assign b_neg   = signB & B[W-1];
  assign mag_a_d = a_neg ? (~A + 1'b1) : A;
  assign mag_b_d = b_neg ? (~B + 1'b1) : B;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
    end
  end

  // NOTE: payload registers are deliberately not reset; a valid bit guards
  // every stage, so their contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg1_q  <= a_neg ^ b_neg;
      ap1_q   <= approx;
      en1_q   <= acc_en;
      clr1_q  <= acc_clr;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: digit products
  // ---------------------------------------------------------------------------
  logic                v2_q;
  logic [NP-1:0][5:0]  pp_q;
  logic                neg2_q, en2_q, clr2_q;

  logic [NP-1:0][5:0]  pp_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        if (!(ap1_q && (i + j < TRUNC))) begin
          pp_d[i*D+j] = {3'b000, mag_a_q[3*i +: 3]} * {3'b000, mag_b_q[3*j +: 3]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q <= 1'b0;
    end else if (adv) begin
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && v1_q) begin
      pp_q   <= pp_d;
      neg2_q <= neg1_q;
      en2_q  <= en1_q;
      clr2_q <= clr1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: sum, sign, accumulate, output register
  // ---------------------------------------------------------------------------
  logic             v3_q;
  logic [ACC_W-1:0] res_q, acc_q;

  logic [P_W-1:0]   p_mag;
  logic [ACC_W-1:0] p_ext, q_val, base, sum, res_d, acc_d;

  always_comb begin
    p_mag = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        p_mag = p_mag + (P_W'(pp_q[i*D+j]) << (3 * (i + j)));
      end
    end
  end

  assign p_ext = {{GUARD{1'b0}}, p_mag};
  assign q_val = neg2_q ? (~p_ext + 1'b1) : p_ext;
  assign base  = clr2_q ? '0 : acc_q;
  assign sum   = base + q_val;   // wraps modulo 2^ACC_W

  always_comb begin
    res_d = q_val;
    acc_d = acc_q;
    if (en2_q) begin
      res_d = sum;
      acc_d = sum;
    end else if (clr2_q) begin
      acc_d = '0;
    end
  end

  // The accumulator commits only as an item enters the output register, so a
  // stalled item can never be added twice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3_q  <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) begin
        res_q <= res_d;
        acc_q <= acc_d;
      end
    end
  end

  assign out_valid  = v3_q;
  assign result_out = res_q;

endmodule
